// File: rtl/submarino_posicao.sv
// Submarine placement controller: turns button edges into a grid anchor/orientation and
// frame-aligned rectangle bounds. Optional blinking while placing is enabled with SUB_BLINK_EN.
module submarino_posicao #(
    parameter int unsigned GRID_X0      = 160,
    parameter int unsigned GRID_Y0      = 80,
    parameter int unsigned CELL         = 32,
    parameter int unsigned GRID_N       = 10,
    parameter int unsigned SUB_LEN      = 3,
    parameter int unsigned BLINK_FRAMES = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rotate,
    input  logic       btn_confirm,
    input  logic       restart,
    output logic [9:0] lineLeft,
    output logic [9:0] lineRight,
    output logic [9:0] colDown,
    output logic [9:0] colUp,
    output logic       placed,
    output logic [3:0] cell_row,
    output logic [3:0] cell_col,
    output logic       vertical,
    output logic       state_dbg
);
    typedef enum logic {PLACING = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [4:0] N5     = 5'(GRID_N);
    localparam logic [4:0] LEN5   = 5'(SUB_LEN);
    localparam logic [9:0] X0_W   = 10'(GRID_X0);
    localparam logic [9:0] Y0_W   = 10'(GRID_Y0);
    localparam logic [9:0] CELL_W = 10'(CELL);
    localparam logic [9:0] RST_LR = 10'(GRID_Y0 + CELL);
    localparam logic [9:0] RST_CU = 10'(GRID_X0 + SUB_LEN * CELL);

    // Button vector order: 0 right, 1 left, 2 down, 3 up, 4 rotate, 5 confirm.
    logic [5:0] btn_now, rise;
    logic [5:0] btn_prev_q, btn_prev_d, pend_q, pend_d;
    state_t     state_q, state_d;
    logic [3:0] row_q, row_d, col_q, col_d;
    logic       vert_q, vert_d;
    logic       moved, visible;
    logic [4:0] row5, col5, rows_span, cols_span;
    logic [9:0] line_left_q, line_left_d, line_right_q, line_right_d;
    logic [9:0] col_down_q, col_down_d, col_up_q, col_up_d;
    logic       placed_q, placed_d;

    assign btn_now   = {btn_confirm, btn_rotate, btn_up, btn_down, btn_left, btn_right};
    assign rise      = btn_now & ~btn_prev_q;
    assign row5      = {1'b0, row_q};
    assign col5      = {1'b0, col_q};
    assign rows_span = vert_q ? LEN5 : 5'd1;
    assign cols_span = vert_q ? 5'd1 : LEN5;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        vert_d     = vert_q;
        btn_prev_d = btn_now;
        pend_d     = pend_q | rise;
        moved      = 1'b0;
        if (state_q == LOCKED) begin
            pend_d = '0;
            if (restart) begin
                state_d = PLACING;
                row_d   = '0;
                col_d   = '0;
                vert_d  = 1'b0;
            end
        end else if (frame_tick) begin
            // Only flags from earlier cycles are applied; an edge on this cycle waits a frame.
            pend_d = rise;
            if (pend_q[5]) begin
                state_d = LOCKED;
            end else if (pend_q[4]) begin
                if (vert_q ? (col5 + LEN5 <= N5) : (row5 + LEN5 <= N5)) begin
                    vert_d = ~vert_q;
                    moved  = 1'b1;
                end
            end else if (pend_q[3]) begin
                if (row_q != 4'd0) begin
                    row_d = row_q - 4'd1;
                    moved = 1'b1;
                end
            end else if (pend_q[2]) begin
                if (row5 + rows_span < N5) begin
                    row_d = row_q + 4'd1;
                    moved = 1'b1;
                end
            end else if (pend_q[1]) begin
                if (col_q != 4'd0) begin
                    col_d = col_q - 4'd1;
                    moved = 1'b1;
                end
            end else if (pend_q[0]) begin
                if (col5 + cols_span < N5) begin
                    col_d = col_q + 4'd1;
                    moved = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= PLACING;
            row_q      <= '0;
            col_q      <= '0;
            vert_q     <= 1'b0;
            btn_prev_q <= '0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            vert_q     <= vert_d;
            btn_prev_q <= btn_prev_d;
            pend_q     <= pend_d;
        end
    end

`ifdef SUB_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          visible_q, visible_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        visible_d   = visible_q;
        if (state_q == LOCKED) begin
            visible_d = 1'b1;
            if (restart) blink_cnt_d = '0;
        end else if (frame_tick) begin
            if (moved) begin
                blink_cnt_d = '0;
                visible_d   = 1'b1;
            end else if (state_d == LOCKED) begin
                visible_d = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                visible_d   = ~visible_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            visible_q   <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            visible_q   <= visible_d;
        end
    end

    assign visible = visible_q;
`else
    logic unused_blink;
    assign unused_blink = ^{BLINK_FRAMES, moved};
    assign visible      = 1'b1;
`endif

    // Bounds follow the registered position one cycle later; zero bounds draw nothing.
    always_comb begin
        line_left_d  = '0;
        line_right_d = '0;
        col_down_d   = '0;
        col_up_d     = '0;
        placed_d     = (state_q == LOCKED);
        if (visible) begin
            line_left_d  = Y0_W + 10'(row_q) * CELL_W;
            line_right_d = Y0_W + 10'(row5 + rows_span) * CELL_W;
            col_down_d   = X0_W + 10'(col_q) * CELL_W;
            col_up_d     = X0_W + 10'(col5 + cols_span) * CELL_W;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_left_q  <= Y0_W;
            line_right_q <= RST_LR;
            col_down_q   <= X0_W;
            col_up_q     <= RST_CU;
            placed_q     <= 1'b0;
        end else begin
            line_left_q  <= line_left_d;
            line_right_q <= line_right_d;
            col_down_q   <= col_down_d;
            col_up_q     <= col_up_d;
            placed_q     <= placed_d;
        end
    end

    assign lineLeft  = line_left_q;
    assign lineRight = line_right_q;
    assign colDown   = col_down_q;
    assign colUp     = col_up_q;
    assign placed    = placed_q;
    assign cell_row  = row_q;
    assign cell_col  = col_q;
    assign vertical  = vert_q;
    assign state_dbg = state_q;
endmodule

// File: doc/submarino_posicao.md
# submarino_posicao

Placement controller for the player's submarine in the ship-placement phase. Turns player button presses into a grid position and orientation, then drives the rectangle bounds (`lineLeft`, `lineRight`, `colDown`, `colUp`) consumed by the submarine draw stage. Bounds change only on frame boundaries, so the draw stage never shows a torn rectangle within a frame.

## Interface
- `GRID_X0`, 160: pixel column of the grid's left edge.
- `GRID_Y0`, 80: pixel row of the grid's top edge.
- `CELL`, 32: cell size in pixels.
- `GRID_N`, 10: cells per grid side.
- `SUB_LEN`, 3: submarine length in cells.
- `BLINK_FRAMES`, 15: frames per blink half-period.
- Constraints: `GRID_X0 + GRID_N*CELL` ≤ 1023 and `GRID_Y0 + GRID_N*CELL` ≤ 1023.

- `clk` in 1: pixel clock.
- `rst_n` in 1: synchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blanking.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: move requests. Level inputs, already synchronised upstream.
- `btn_rotate` in 1: orientation toggle request.
- `btn_confirm` in 1: lock the placement.
- `restart` in 1: return to placing from the locked state.
- `lineLeft` out 10: exclusive top row bound.
- `lineRight` out 10: exclusive bottom row bound.
- `colDown` out 10: exclusive left column bound.
- `colUp` out 10: exclusive right column bound.
- `placed` out 1: high while the placement is locked.
- `cell_row`, `cell_col` out 4 each: anchor cell (top-left cell of the submarine).
- `vertical` out 1: 0 = horizontal, 1 = vertical.

## Operation
- **States:** PLACING and LOCKED.
  - PLACING → LOCKED: on an applied confirm.
  - LOCKED → PLACING: on `restart` (any cycle). This also resets the anchor to (0,0), orientation to horizontal and the blink state.
- **Request capture:** each button's previous level is registered. A rising edge sets that button's pending flag.
- **Request application:** on `frame_tick` in PLACING, only the highest-priority pending request is applied.
  - Priority: confirm > rotate > up > down > left > right.
  - All pending flags clear on that same cycle.
  - In LOCKED, pending flags are cleared and never applied.
- **Move legality** (horizontal span is `SUB_LEN` columns × 1 row; vertical span is 1 column × `SUB_LEN` rows):
  - An illegal move leaves the position unchanged; there is no wrap.
  - Up is legal when `row` > 0.
  - Down is legal when `row + rows_spanned` < `GRID_N`.
  - Left and right follow the same rule on columns.
- **Rotate:** toggles `vertical` about the anchor. It is ignored if the new span would leave the grid, e.g. horizontal at column 8 with `SUB_LEN` 3 is already illegal; vertical at row 8 cannot rotate when `row + SUB_LEN` > `GRID_N`.
- **Bounds arithmetic** (10-bit unsigned, no overflow given the constraints):
  - `lineLeft` = `GRID_Y0 + row*CELL`.
  - `lineRight` = `GRID_Y0 + (row + rows_spanned)*CELL`.
  - `colDown` = `GRID_X0 + col*CELL`.
  - `colUp` = `GRID_X0 + (col + cols_spanned)*CELL`.
  - The draw stage's strict comparisons leave a 1-pixel gap at every edge.
- **Invisible:** all four bounds are driven to 0, which gives an empty rectangle.

## Timing
- **Reset values:** state PLACING, `cell_row` 0, `cell_col` 0, `vertical` 0, `placed` 0, all pending flags 0, blink counter 0, visible 1. Bounds at reset: `lineLeft` 80, `lineRight` 112, `colDown` 160, `colUp` 256.
- **Latency:** position/orientation registers update on the `frame_tick` cycle. Bounds outputs are registered and update exactly one cycle later. `placed` rises in the same cycle as the bounds update.
- **Edge coincident with `frame_tick`:** the edge is captured as pending but is not applied at this tick. It is applied at the next `frame_tick`.
- **`restart` coincident with `frame_tick`:** `restart` wins and no request is applied.
- **`rst_n` low:** overrides everything on the next clock edge, including mid-frame.
- **Held buttons:** a button held across frames produces only one request, because capture is edge-based.

## Configuration
- **`SUB_BLINK_EN` defined:**
  - In PLACING, visible toggles on every `BLINK_FRAMES`-th `frame_tick`.
  - The blink counter counts 0..`BLINK_FRAMES`−1 and then wraps.
  - Any applied (legal) move or rotate resets the counter to 0 and sets visible to 1.
  - LOCKED forces visible to 1.
- **`SUB_BLINK_EN` undefined:** visible is constantly 1, there is no counter, and bounds always reflect the position.

## Test plan
- **Reset defaults:** after reset, bounds are 80/112/160/256, `placed`=0 and `vertical`=0.
- **Move right:** pulse `btn_right`, then `frame_tick` → `cell_col`=1; one cycle later `colDown`=192 and `colUp`=288.
- **Clamp at edge:** at `cell_col`=7, horizontal, pulse `btn_right` + tick → position unchanged, bounds unchanged.
- **Rotate:**
  - At (0,0), pulse `btn_rotate` + tick → `vertical`=1, `lineRight`=176, `colUp`=192.
  - At row 8, vertical is illegal. From horizontal at row 8, rotate is ignored.
- **Simultaneous requests:** `btn_up` and `btn_left` edges in the same frame at (2,2) → only up is applied, giving (1,2). The left flag is cleared.
- **Lock and restart:** confirm + tick → `placed`=1 and further moves are ignored. Then `restart` → (0,0), horizontal, `placed`=0.
- **With `SUB_BLINK_EN`:** after 15 ticks with no moves, all bounds are 0. After another 15 ticks, the bounds return.
